// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the RV32M multiply/divide sequencer:
//   - sequencer state type (IDLE, CALC, FIX, DONE)
//   - funct3 operation codes for MUL..REMU
//   - iteration count and last-iteration counter value
//   - small decode helpers used by the sequencer and its fix-up stage
// Optional feature macro honoured by the design files: MULDIV_FAST_MUL_EN
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } mdState_e;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    localparam int         MD_ITER      = 32;
    localparam logic [4:0] MD_LAST_ITER = 5'(MD_ITER - 1);

    // True for the four divide/remainder operations.
    function automatic logic isDivOp(input logic [2:0] f);
        return f inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    endfunction

    // True when the remainder, not the quotient, is the result.
    function automatic logic isRemOp(input logic [2:0] f);
        return f inside {MD_REM, MD_REMU};
    endfunction

    // True when the upper half of the 64-bit product is the result.
    function automatic logic isMulHigh(input logic [2:0] f);
        return f inside {MD_MULH, MD_MULHSU, MD_MULHU};
    endfunction

    // rs1 is interpreted as two's complement for these operations.
    function automatic logic rs1Signed(input logic [2:0] f);
        return f inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    // rs2 is interpreted as two's complement for these operations.
    function automatic logic rs2Signed(input logic [2:0] f);
        return f inside {MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter
// Combinational single-step update of the {accumulator, operand} pair.
// Ports:
//   isDiv_i  1   select restoring-divide step (1) or shift-add multiply step (0)
//   acc_i    64  current accumulator
//   opnd_i   32  multiplicand (multiply) or divisor (divide) magnitude
//   acc_o    64  accumulator after one iteration
// Multiply: accumulator low half holds the remaining multiplier bits, the
// product grows in from the top. Divide: upper half is the partial
// remainder, lower half shifts the dividend out and the quotient in.
// Optional feature macro (handled by the top): MULDIV_FAST_MUL_EN
module muldiv_iter (
    input  logic        isDiv_i,
    input  logic [63:0] acc_i,
    input  logic [31:0] opnd_i,
    output logic [63:0] acc_o
);

    logic [32:0] sum;
    logic        fits;
    logic [31:0] remNext;

    // One iteration. The divide compare uses 33 bits because the partial
    // remainder can reach 2^32-2 and would lose its top bit after the shift.
    always_comb begin
        sum     = {1'b0, acc_i[63:32]} + {1'b0, opnd_i};
        fits    = (acc_i[63:31] >= {1'b0, opnd_i});
        remNext = acc_i[62:31] - opnd_i;
        if (isDiv_i) begin
            if (fits) begin
                acc_o = {remNext, acc_i[30:0], 1'b1};
            end else begin
                acc_o = {acc_i[62:0], 1'b0};
            end
        end else if (acc_i[0]) begin
            acc_o = {sum, acc_i[31:1]};
        end else begin
            acc_o = {1'b0, acc_i[63:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
// Multi-cycle RV32M multiply/divide sequencer. Accepts one operation,
// iterates 32 cycles on magnitudes, then applies the sign fix-up and
// returns the result with a one-cycle done pulse.
// Ports:
//   clk       1   clock, rising edge
//   rst_n     1   asynchronous active-low reset
//   start     1   request, accepted in IDLE or DONE when kill is low
//   funct3    3   operation select (MUL..REMU)
//   rs1_data  32  multiplicand / dividend
//   rs2_data  32  multiplier / divisor
//   kill      1   flush: abandon the operation, suppress done
//   busy      1   high in CALC and FIX (pipeline stall)
//   done      1   one-cycle result-valid pulse
//   out       32  result, held until the next completed operation
// Optional feature: define MULDIV_FAST_MUL_EN to compute multiplies with a
// single-cycle combinational product (busy cycle 1, done cycle 2).
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        kill,
    output logic        busy,
    output logic        done,
    output logic [31:0] out
);

    mdState_e    state_q, state_d;
    logic [2:0]  f3_q, f3_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opnd_q, opnd_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        negRes_q, negRes_d;
    logic        negRem_q, negRem_d;
    logic        special_q, special_d;
    logic [31:0] out_q, out_d;

    logic        a1Neg, a2Neg;
    logic [31:0] abs1, abs2;
    logic        divZero, divOvf;
    logic        isDivQ;
    logic [63:0] accStep;
    logic [63:0] prod;
    logic [31:0] quo, rem;
    logic [31:0] fixResult;
`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] fastA, fastB;
`endif

    // Operand sign handling for the request presented this cycle.
    assign a1Neg   = rs1Signed(funct3) & rs1_data[31];
    assign a2Neg   = rs2Signed(funct3) & rs2_data[31];
    assign abs1    = a1Neg ? (~rs1_data + 32'd1) : rs1_data;
    assign abs2    = a2Neg ? (~rs2_data + 32'd1) : rs2_data;
    assign divZero = (rs2_data == 32'd0);
    assign divOvf  = rs1Signed(funct3) & (rs1_data == 32'h8000_0000)
                     & (rs2_data == 32'hFFFF_FFFF);
    assign isDivQ  = isDivOp(f3_q);

    muldiv_iter u_iter (
        .isDiv_i (isDivQ),
        .acc_i   (acc_q),
        .opnd_i  (opnd_q),
        .acc_o   (accStep)
    );

    // Result selection and sign correction for the FIX state. Special
    // divide cases already hold their final values and bypass correction.
    always_comb begin
`ifdef MULDIV_FAST_MUL_EN
        fastA = {{32{rs1Signed(f3_q) & acc_q[63]}}, acc_q[63:32]};
        fastB = {{32{rs2Signed(f3_q) & acc_q[31]}}, acc_q[31:0]};
        prod  = fastA * fastB;
`else
        prod = negRes_q ? (~acc_q + 64'd1) : acc_q;
`endif
        if (special_q) begin
            quo = acc_q[31:0];
            rem = acc_q[63:32];
        end else begin
            quo = negRes_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
            rem = negRem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
        end
        if (isDivQ) begin
            fixResult = isRemOp(f3_q) ? rem : quo;
        end else begin
            fixResult = isMulHigh(f3_q) ? prod[63:32] : prod[31:0];
        end
    end

    // Next-state and output logic. DONE accepts a new request just like
    // IDLE so back-to-back operations lose no cycle. Kill overrides
    // everything and leaves out untouched.
    always_comb begin
        state_d   = state_q;
        f3_d      = f3_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        cnt_d     = cnt_q;
        negRes_d  = negRes_q;
        negRem_d  = negRem_q;
        special_d = special_q;
        out_d     = out_q;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            MD_IDLE, MD_DONE: begin
                done    = (state_q == MD_DONE) && !kill;
                state_d = MD_IDLE;
                if (start && !kill) begin
                    f3_d      = funct3;
                    cnt_d     = 5'd0;
                    special_d = 1'b0;
                    negRes_d  = a1Neg ^ a2Neg;
                    negRem_d  = a1Neg;
                    if (isDivOp(funct3)) begin
                        opnd_d = abs2;
                        if (divZero) begin
                            acc_d     = {rs1_data, 32'hFFFF_FFFF};
                            special_d = 1'b1;
                            state_d   = MD_FIX;
                        end else if (divOvf) begin
                            acc_d     = {32'd0, 32'h8000_0000};
                            special_d = 1'b1;
                            state_d   = MD_FIX;
                        end else begin
                            acc_d   = {32'd0, abs1};
                            state_d = MD_CALC;
                        end
                    end else begin
`ifdef MULDIV_FAST_MUL_EN
                        acc_d   = {rs1_data, rs2_data};
                        state_d = MD_FIX;
`else
                        opnd_d  = abs1;
                        acc_d   = {32'd0, abs2};
                        state_d = MD_CALC;
`endif
                    end
                end
            end
            MD_CALC: begin
                busy  = 1'b1;
                acc_d = accStep;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == MD_LAST_ITER) begin
                    state_d = MD_FIX;
                end
            end
            MD_FIX: begin
                busy    = 1'b1;
                out_d   = fixResult;
                state_d = MD_DONE;
            end
            default: begin
                state_d = MD_IDLE;
            end
        endcase

        if (kill) begin
            state_d = MD_IDLE;
            out_d   = out_q;
        end
    end

    // State and datapath registers; reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MD_IDLE;
            f3_q      <= 3'd0;
            acc_q     <= 64'd0;
            opnd_q    <= 32'd0;
            cnt_q     <= 5'd0;
            negRes_q  <= 1'b0;
            negRem_q  <= 1'b0;
            special_q <= 1'b0;
            out_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            f3_q      <= f3_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            cnt_q     <= cnt_d;
            negRes_q  <= negRes_d;
            negRem_q  <= negRem_d;
            special_q <= special_d;
            out_q     <= out_d;
        end
    end

    assign out = out_q;

endmodule
